// File: rtl/spraid_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spraid_wb_arbiter
// Purpose  : Round-robin arbiter that lets two classic Wishbone masters share
//            the SPI RAID slave. It runs one transaction at a time and inserts
//            one all-zero DRAIN cycle between transactions. A watchdog returns
//            err to the owner if the slave never acknowledges.
// Ports    : wb_clk_i / wb_rst_i (async, active-low)
//            m0_* / m1_*  : master-side Wishbone ports
//            s_*          : slave-side Wishbone port
//            grant_o      : one-hot current owner, 00 when nobody owns the bus
// Revision : 1.0  initial release
// ============================================================================
module spraid_wb_arbiter #(
  parameter int TIMEOUT = 4096
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_stall_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_stall_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_stall_i,
  output logic [1:0]  grant_o
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic          owner, owner_nx;
  logic          last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic req0, req1, winner;
  logic in_own, own0, own1;
  logic own_cyc, own_stb, own_we;
  logic cnt_max, ack_fire, err_fire, abort;

  assign req0   = m0_cyc_i & m0_stb_i;
  assign req1   = m1_cyc_i & m1_stb_i;
  // Alternate on contention; otherwise the lone requester wins.
  assign winner = (req0 & req1) ? ~last : req1;

  assign in_own = (state == OWN);
  assign own0   = in_own & ~owner;
  assign own1   = in_own &  owner;

  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner ? m1_stb_i : m0_stb_i;
  assign own_we  = owner ? m1_we_i  : m0_we_i;

  // Exit priority: ack > slave err > watchdog err > owner abort.
  assign cnt_max  = (cnt == CNT_LAST);
  assign ack_fire = in_own & s_ack_i;
  assign err_fire = in_own & ~s_ack_i & (s_err_i | cnt_max);
  assign abort    = in_own & ~s_ack_i & ~s_err_i & ~cnt_max & ~own_cyc;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;  // master 0 wins the first contention
      cnt   <= '0;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = cnt;
    case (state)
      IDLE, DRAIN: begin
        if (req0 | req1) begin
          state_nx = OWN;
          owner_nx = winner;
          cnt_nx   = '0;
        end else begin
          state_nx = IDLE;
        end
      end
      OWN: begin
        if (!cnt_max) cnt_nx = cnt + CW'(1);
        if (ack_fire | err_fire | abort) begin
          state_nx = DRAIN;
          last_nx  = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Slave side: everything is zero outside OWN so the slave can clear its ack.
  assign s_cyc_o = in_own;
  assign s_stb_o = in_own & own_stb;
  assign s_we_o  = in_own & own_we;
  assign s_adr_o = in_own ? (owner ? m1_adr_i : m0_adr_i) : 32'd0;
  assign s_dat_o = in_own ? (owner ? m1_dat_i : m0_dat_i) : 32'd0;

  // Master side: owner sees the slave directly; non-owners are stalled.
  assign m0_ack_o   = own0 & ack_fire;
  assign m0_err_o   = own0 & err_fire;
  assign m0_dat_o   = own0 ? s_dat_i : 32'd0;
  assign m0_stall_o = own0 ? s_stall_i : req0;

  assign m1_ack_o   = own1 & ack_fire;
  assign m1_err_o   = own1 & err_fire;
  assign m1_dat_o   = own1 ? s_dat_i : 32'd0;
  assign m1_stall_o = own1 ? s_stall_i : req1;

  assign grant_o = in_own ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_spraid_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spraid_wb_arbiter
// Purpose  : Directed bench for spraid_wb_arbiter (TIMEOUT = 16). Inputs change
//            1 time unit after each rising edge, outputs are checked 1 unit
//            after that.
// Revision : 1.0  initial release
// ============================================================================
module tb_spraid_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic        m0_ack, m0_err, m0_stall;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic        m1_ack, m1_err, m1_stall;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic        s_ack, s_err, s_stall;
  logic [1:0]  grant;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spraid_wb_arbiter #(.TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_stall_o(m0_stall),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_stall_o(m1_stall),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_dat_i(s_rdat),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_stall_i(s_stall),
    .grant_o(grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_wdat = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_wdat = 0;
    s_rdat = 0; s_ack = 0; s_err = 0; s_stall = 0;

    // ---------------- reset state ----------------
    #3;
    chk("rst_s_cyc", {31'd0, s_cyc}, 0);
    chk("rst_s_stb", {31'd0, s_stb}, 0);
    chk("rst_grant", {30'd0, grant}, 0);
    chk("rst_s_adr", s_adr, 0);
    chk("rst_m0_stall", {31'd0, m0_stall}, 0);
    m1_cyc = 1; m1_stb = 1;
    #1;
    chk("rst_m1_stall_req", {31'd0, m1_stall}, 1);
    chk("rst_m1_ack", {31'd0, m1_ack}, 0);
    m1_cyc = 0; m1_stb = 0;
    @(posedge clk); #2; rst_n = 1'b1;

    // ---------------- single read with stall ----------------
    tick();  // cycle 0
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0010;
    #1;
    chk("rd_c0_stb", {31'd0, s_stb}, 0);
    chk("rd_c0_m0_stall", {31'd0, m0_stall}, 1);
    for (int c = 1; c <= 11; c++) begin
      tick();
      s_stall = (c <= 10);
      s_ack   = (c == 11);
      s_rdat  = (c == 11) ? 32'hDEAD_BEEF : 32'h1234_5678;
      #1;
      chk("rd_stb", {31'd0, s_stb}, 1);
      chk("rd_adr", s_adr, 32'h3000_0010);
      chk("rd_grant", {30'd0, grant}, 1);
      chk("rd_m0_stall", {31'd0, m0_stall}, (c <= 10) ? 1 : 0);
      chk("rd_m0_ack", {31'd0, m0_ack}, (c == 11) ? 1 : 0);
      chk("rd_m0_dat", m0_rdat, (c == 11) ? 32'hDEAD_BEEF : 32'h1234_5678);
      chk("rd_m1_out", {m1_rdat[29:0], m1_ack, m1_err}, 0);
      chk("rd_m1_stall", {31'd0, m1_stall}, 0);
    end
    tick();  // cycle 12
    m0_cyc = 0; m0_stb = 0; s_ack = 0; s_rdat = 0;
    #1;
    chk("rd_c12_cyc", {31'd0, s_cyc}, 0);
    chk("rd_c12_ack", {31'd0, m0_ack}, 0);

    // ---------------- contention after reset ----------------
    tick();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    m0_adr = 32'h3000_0000; m1_adr = 32'h3000_0004;
    #1;
    chk("ct_c0_grant", {30'd0, grant}, 0);
    for (int t = 0; t < 4; t++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        s_ack = (c == 3);
        #1;
        chk("ct_grant", {30'd0, grant}, (t % 2 == 0) ? 1 : 2);
        chk("ct_s_adr", s_adr, (t % 2 == 0) ? 32'h3000_0000 : 32'h3000_0004);
        chk("ct_m0_ack", {31'd0, m0_ack}, (c == 3 && t % 2 == 0) ? 1 : 0);
        chk("ct_m1_ack", {31'd0, m1_ack}, (c == 3 && t % 2 == 1) ? 1 : 0);
      end
      tick();
      s_ack = 0;
      if (t == 3) begin
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      end
      #1;
      chk("ct_drain_grant", {30'd0, grant}, 0);
      chk("ct_drain_cyc", {31'd0, s_cyc}, 0);
    end

    // ---------------- timeout on m1 write ----------------
    tick();  // IDLE, cycle 0
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h3000_0800; m1_wdat = 32'h0000_0005;
    #1;
    chk("to_c0_grant", {30'd0, grant}, 0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      #1;
      chk("to_grant", {30'd0, grant}, 2);
      chk("to_err", {31'd0, m1_err}, (c == 16) ? 1 : 0);
      chk("to_ack", {31'd0, m1_ack}, 0);
      if (c == 1) begin
        chk("to_we", {31'd0, s_we}, 1);
        chk("to_adr", s_adr, 32'h3000_0800);
        chk("to_wdat", s_wdat, 32'h0000_0005);
      end
    end
    tick();
    m1_cyc = 0; m1_stb = 0; m1_we = 0;
    #1;
    chk("to_next_cyc", {31'd0, s_cyc}, 0);
    chk("to_next_err", {31'd0, m1_err}, 0);

    // ---------------- ack colliding with timeout ----------------
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h3000_0020;
    for (int c = 1; c <= 16; c++) begin
      tick();
      s_ack = (c == 16);
      #1;
      chk("col_ack", {31'd0, m0_ack}, (c == 16) ? 1 : 0);
      chk("col_err", {31'd0, m0_err}, 0);
    end
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    chk("col_next_cyc", {31'd0, s_cyc}, 0);

    // ---------------- reset in the middle of a transaction ----------------
    tick();
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h3000_0004;
    for (int c = 1; c <= 4; c++) begin
      tick();
      #1;
      chk("rm_grant", {30'd0, grant}, 2);
    end
    tick();  // 5th OWN cycle
    #1;
    chk("rm_pre_cyc", {31'd0, s_cyc}, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_cyc", {31'd0, s_cyc}, 0);
    chk("rm_stb", {31'd0, s_stb}, 0);
    chk("rm_grant0", {30'd0, grant}, 0);
    chk("rm_m1_resp", {30'd0, m1_ack, m1_err}, 0);
    m1_cyc = 0; m1_stb = 0;
    #1;
    rst_n = 1'b1;

    // ---------------- both request after reset, then m0 aborts ----------------
    tick();  // cycle 0
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    #1;
    chk("ab_c0_grant", {30'd0, grant}, 0);
    tick();
    #1;
    chk("ab_c1_grant", {30'd0, grant}, 1);
    tick();
    #1;
    chk("ab_c2_grant", {30'd0, grant}, 1);
    chk("ab_c2_m1_stall", {31'd0, m1_stall}, 1);
    tick();  // 3rd OWN cycle: m0 drops cyc
    m0_cyc = 0; m0_stb = 0;
    #1;
    chk("ab_c3_resp", {30'd0, m0_ack, m0_err}, 0);
    tick();
    #1;
    chk("ab_drain_grant", {30'd0, grant}, 0);
    chk("ab_drain_cyc", {31'd0, s_cyc}, 0);
    chk("ab_drain_resp", {30'd0, m0_ack, m0_err}, 0);
    tick();
    s_ack = 1; s_rdat = 32'h0000_00A5;
    #1;
    chk("ab_m1_grant", {30'd0, grant}, 2);
    chk("ab_m1_ack", {31'd0, m1_ack}, 1);
    chk("ab_m1_dat", m1_rdat, 32'h0000_00A5);
    chk("ab_m0_resp", {30'd0, m0_ack, m0_err}, 0);
    tick();
    s_ack = 0; s_rdat = 0; m1_cyc = 0; m1_stb = 0;
    #1;
    chk("ab_end_grant", {30'd0, grant}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
